riscv_pipe_core: RTL and testbench
==================================

Name: riscv_pipe_core

Overview:
- Self-contained RV32I integer-subset core with a 5-stage in-order pipeline: IF, ID, EX, MEM, WB.
- Contains its own instruction ROM and a 32x32 register file.
- No external bus; the only ports are clock and reset.
- Top-level block of the CPU; testbenches preload the ROM through a hierarchical path and inspect register-file contents through a hierarchical path.

Parameters:
- ROM_DEPTH, 4096, instruction ROM depth in 32-bit words; power of two.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rstn  input  1  synchronous active-high reset; core is held in reset while rstn=1 at a rising clk edge.

Behaviour:
- Reset (sync, active-high):
  - PC = RESET_PC.
  - All pipeline registers hold NOP (32'h0000_0013) with write-enable 0.
  - All regs_mem entries = 0.
  - ROM contents are not touched by reset.
- IF stage:
  - ROM read is combinational: word index pc[log2(ROM_DEPTH)+1:2].
  - Fetched instruction is registered into IF/ID.
  - PC += 4 every cycle; index wraps modulo ROM_DEPTH.
  - No stalls, no branches.
- ID stage:
  - Decode opcode, funct3, funct7, rd, rs1, rs2; sign-extend imm[31:20].
  - Read rs1 and rs2 from the regfile.
  - Regfile write-through: a WB write to the same register in the same cycle is seen by the ID read.
- Supported instructions:
  - OP-IMM (7'b0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP (7'b0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - Any other encoding is treated as NOP (no register write).
- EX stage:
  - 32-bit ALU with two's-complement wrap on overflow; shifts use operand[4:0].
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
- Forwarding into EX operands, priority order:
  1. EX/MEM result, if that instruction writes and rd!=0 and rd matches.
  2. MEM/WB result, under the same conditions.
  3. ID/EX registered value.
  - Back-to-back dependent instructions therefore never stall.
- MEM stage: pass-through register (no data memory).
- WB stage:
  - Writes regs_mem[rd] when we=1 and rd!=0.
  - x0 always reads 0.
- Latency: an instruction fetched at cycle N has its result architecturally visible in regs_mem after the edge ending cycle N+4.
- Reset deasserted mid-program: execution restarts from RESET_PC; all in-flight instructions are discarded.

Optional Feature:
- Macro RISCV_CORE_TRACE_EN.
- Defined: on every WB write, a simulation-only $display prints "WB x<rd> = <hex value> @ <time>".
- Undefined: no trace code is compiled; functionality is identical.

Decomposition:
- Package riscv_defines_pkg holds:
  - opcode constants (OPC_OP_IMM, OPC_OP);
  - funct3 codes;
  - ALU-op enum;
  - NOP_INST;
  - XLEN=32;
  - REG_ADDR_W=5.
- Sub-module riscv_regfile, instance u_regfile: 32x32 array named regs_mem, 2 combinational read ports with write-through, 1 write port.
- ROM: instance u_rom wrapping a generic ROM u_gnrl_rom whose storage array is mem_r[0:ROM_DEPTH-1].
  - Preloaded via $readmemb.
  - The hierarchical paths u_rom.u_gnrl_rom.mem_r and u_regfile.regs_mem are mandatory.

Test Plan:
- Reset: hold rstn=1 for 2 cycles, then release → PC=0 and regs_mem[1..31]=0 before the first writeback; first WB occurs 5 cycles after release.
- Dependent ADDI chain (exercises EX/MEM and MEM/WB forwarding):
  - Program: addi x1,x0,1; addi x2,x1,2; addi x3,x2,3; addi x4,x3,4; addi x5,x4,5; NOPs.
  - After 50 cycles: x1=1, x2=3, x3=6, x4=10, x5=15.
- R-type and logic:
  - Program: addi x1,x0,-7; addi x2,x0,3; sub x3,x1,x2; slt x4,x1,x2; sltu x5,x1,x2; xori x6,x1,-1.
  - Expect x3=-10, x4=1, x5=0, x6=6.
- x0 protection: addi x0,x0,5; add x7,x0,x0 → x0=0, x7=0.
- Illegal/unsupported word 32'hFFFF_FFFF between two ADDIs → treated as NOP; surrounding results correct; no register changes from it.
- Wrap and reset mid-run:
  - Fill the ROM with a repeating increment (addi x1,x1,1) and run past ROM_DEPTH words → PC wraps and x1 keeps counting.
  - Assert rstn for 1 cycle mid-run → x1=0 and PC=0 afterwards.

Source files
------------

// File: rtl/riscv_defines_pkg.sv
// Shared definitions for the riscv_pipe_core slice: ISA field constants,
// ALU operation encoding and the ALU-op decode helper.
package riscv_defines_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [3:0] {
      AluAdd, AluSub, AluSll, AluSlt, AluSltu,
      AluXor, AluSrl, AluSra, AluOr,  AluAnd
   } alu_op_e;

   // alt is instruction bit 30; it selects SUB only for register-register ops
   function automatic alu_op_e decode_alu_op(input logic [2:0] funct3,
                                             input logic       alt,
                                             input logic       is_op);
      alu_op_e op;
      op = AluAdd;
      case (funct3)
         F3_ADD_SUB: op = (is_op && alt) ? AluSub : AluAdd;
         F3_SLL:     op = AluSll;
         F3_SLT:     op = AluSlt;
         F3_SLTU:    op = AluSltu;
         F3_XOR:     op = AluXor;
         F3_SRL_SRA: op = alt ? AluSra : AluSrl;
         F3_OR:      op = AluOr;
         F3_AND:     op = AluAnd;
         default:    op = AluAdd;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/riscv_gnrl_rom.sv
// Generic asynchronous-read ROM. Contents come from a hierarchical preload of mem_r.
module riscv_gnrl_rom #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned DW    = 32
) (
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  output logic [DW-1:0]            data_o
);

  logic [DW-1:0] mem_r [0:DEPTH-1];

  assign data_o = mem_r[addr_i];

endmodule

// File: rtl/riscv_regfile.sv
// 32 x XLEN integer register file: two combinational read ports with
// write-through from the write port, x0 reads as zero, sync active-high reset.
module riscv_regfile
   import riscv_defines_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [REG_ADDR_W-1:0] raddr_a_i,
   output logic [XLEN-1:0]       rdata_a_o,
   input  logic [REG_ADDR_W-1:0] raddr_b_i,
   output logic [XLEN-1:0]       rdata_b_o,
   input  logic                  we_i,
   input  logic [REG_ADDR_W-1:0] waddr_i,
   input  logic [XLEN-1:0]       wdata_i
);

   localparam int unsigned NREGS = 2 ** REG_ADDR_W;

   logic [XLEN-1:0] regs_mem [0:NREGS-1];
   logic            wr_en;

   assign wr_en = we_i && (waddr_i != '0);

   // Register write; reset clears every entry
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_mem[i] <= '0;
         end
      end else if (wr_en) begin
         regs_mem[waddr_i] <= wdata_i;
      end
   end

   // Read ports: x0 is zero, a same-cycle write is forwarded to the reader
   always_comb begin
      rdata_a_o = regs_mem[raddr_a_i];
      if (raddr_a_i == '0) begin
         rdata_a_o = '0;
      end else if (wr_en && (waddr_i == raddr_a_i)) begin
         rdata_a_o = wdata_i;
      end
      rdata_b_o = regs_mem[raddr_b_i];
      if (raddr_b_i == '0) begin
         rdata_b_o = '0;
      end else if (wr_en && (waddr_i == raddr_b_i)) begin
         rdata_b_o = wdata_i;
      end
   end

endmodule

// File: rtl/riscv_rom.sv
// Instruction ROM wrapper: word-indexed, combinational read.
module riscv_rom
   import riscv_defines_pkg::*;
#(
   parameter int unsigned ROM_DEPTH = 4096
) (
   input  logic [$clog2(ROM_DEPTH)-1:0] addr_i,
   output logic [XLEN-1:0]              inst_o
);

   riscv_gnrl_rom #(
      .DEPTH (ROM_DEPTH),
      .DW    (XLEN)
   ) u_gnrl_rom (
      .addr_i (addr_i),
      .data_o (inst_o)
   );

endmodule

// File: rtl/riscv_pipe_core.sv
// Five-stage in-order RV32I integer subset core (IF ID EX MEM WB) with full
// EX/MEM and MEM/WB forwarding, no stalls and no branches.
// Optional macro RISCV_CORE_TRACE_EN adds a simulation-only writeback trace.
module riscv_pipe_core
   import riscv_defines_pkg::*;
#(
   parameter int unsigned ROM_DEPTH = 4096,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input logic clk,
   input logic rstn
);

   localparam int unsigned IDX_W = $clog2(ROM_DEPTH);

   // IF
   logic [XLEN-1:0]  pc_q;
   logic [IDX_W-1:0] rom_idx;
   logic [XLEN-1:0]  if_inst;
   logic [XLEN-1:0]  ifid_inst_q;
   logic             unused_pc;

   // ID
   logic [6:0]            id_opcode;
   logic [REG_ADDR_W-1:0] id_rd, id_rs1, id_rs2;
   logic [2:0]            id_funct3;
   logic [XLEN-1:0]       id_imm, id_rs1_val, id_rs2_val;
   logic                  id_is_op, id_is_imm, id_we;
   alu_op_e               id_alu_op;

   // ID/EX
   alu_op_e               idex_alu_op_q;
   logic [REG_ADDR_W-1:0] idex_rd_q, idex_rs1_q, idex_rs2_q;
   logic [XLEN-1:0]       idex_rs1_val_q, idex_rs2_val_q, idex_imm_q;
   logic                  idex_use_imm_q, idex_we_q;

   // EX
   logic [XLEN-1:0] ex_a, ex_rs2_fwd, ex_b, ex_res;

   // EX/MEM and MEM/WB
   logic [XLEN-1:0]       exmem_res_q, memwb_res_q;
   logic [REG_ADDR_W-1:0] exmem_rd_q, memwb_rd_q;
   logic                  exmem_we_q, memwb_we_q;

   assign rom_idx   = pc_q[IDX_W+1:2];
   assign unused_pc = ^{pc_q[XLEN-1:IDX_W+2], pc_q[1:0]};

   riscv_rom #(
      .ROM_DEPTH (ROM_DEPTH)
   ) u_rom (
      .addr_i (rom_idx),
      .inst_o (if_inst)
   );

   // PC advances every cycle; fetched word is latched into IF/ID
   always_ff @(posedge clk) begin
      if (rstn) begin
         pc_q        <= RESET_PC;
         ifid_inst_q <= NOP_INST;
      end else begin
         pc_q        <= pc_q + 32'd4;
         ifid_inst_q <= if_inst;
      end
   end

   assign id_opcode = ifid_inst_q[6:0];
   assign id_rd     = ifid_inst_q[11:7];
   assign id_funct3 = ifid_inst_q[14:12];
   assign id_rs1    = ifid_inst_q[19:15];
   assign id_rs2    = ifid_inst_q[24:20];
   assign id_imm    = {{(XLEN-12){ifid_inst_q[31]}}, ifid_inst_q[31:20]};
   assign id_is_op  = (id_opcode == OPC_OP);
   assign id_is_imm = (id_opcode == OPC_OP_IMM);
   // Anything other than OP / OP-IMM retires as a NOP
   assign id_we     = id_is_op || id_is_imm;
   assign id_alu_op = decode_alu_op(id_funct3, ifid_inst_q[30], id_is_op);

   riscv_regfile u_regfile (
      .clk_i     (clk),
      .rst_i     (rstn),
      .raddr_a_i (id_rs1),
      .rdata_a_o (id_rs1_val),
      .raddr_b_i (id_rs2),
      .rdata_b_o (id_rs2_val),
      .we_i      (memwb_we_q),
      .waddr_i   (memwb_rd_q),
      .wdata_i   (memwb_res_q)
   );

   // ID/EX register; reset value is the decoded NOP
   always_ff @(posedge clk) begin
      if (rstn) begin
         idex_alu_op_q  <= AluAdd;
         idex_rd_q      <= '0;
         idex_rs1_q     <= '0;
         idex_rs2_q     <= '0;
         idex_rs1_val_q <= '0;
         idex_rs2_val_q <= '0;
         idex_imm_q     <= '0;
         idex_use_imm_q <= 1'b1;
         idex_we_q      <= 1'b0;
      end else begin
         idex_alu_op_q  <= id_alu_op;
         idex_rd_q      <= id_rd;
         idex_rs1_q     <= id_rs1;
         idex_rs2_q     <= id_rs2;
         idex_rs1_val_q <= id_rs1_val;
         idex_rs2_val_q <= id_rs2_val;
         idex_imm_q     <= id_imm;
         idex_use_imm_q <= id_is_imm;
         idex_we_q      <= id_we;
      end
   end

   // Operand forwarding: youngest producer (EX/MEM) wins over MEM/WB
   always_comb begin
      ex_a = idex_rs1_val_q;
      if (exmem_we_q && (exmem_rd_q != '0) && (exmem_rd_q == idex_rs1_q)) begin
         ex_a = exmem_res_q;
      end else if (memwb_we_q && (memwb_rd_q != '0) && (memwb_rd_q == idex_rs1_q)) begin
         ex_a = memwb_res_q;
      end
      ex_rs2_fwd = idex_rs2_val_q;
      if (exmem_we_q && (exmem_rd_q != '0) && (exmem_rd_q == idex_rs2_q)) begin
         ex_rs2_fwd = exmem_res_q;
      end else if (memwb_we_q && (memwb_rd_q != '0) && (memwb_rd_q == idex_rs2_q)) begin
         ex_rs2_fwd = memwb_res_q;
      end
      ex_b = idex_use_imm_q ? idex_imm_q : ex_rs2_fwd;
   end

   // ALU: wrapping arithmetic, shift amount from ex_b[4:0]
   always_comb begin
      ex_res = '0;
      case (idex_alu_op_q)
         AluAdd:  ex_res = ex_a + ex_b;
         AluSub:  ex_res = ex_a - ex_b;
         AluSll:  ex_res = ex_a << ex_b[4:0];
         AluSlt:  ex_res = {{(XLEN-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
         AluSltu: ex_res = {{(XLEN-1){1'b0}}, (ex_a < ex_b)};
         AluXor:  ex_res = ex_a ^ ex_b;
         AluSrl:  ex_res = ex_a >> ex_b[4:0];
         AluSra:  ex_res = $unsigned($signed(ex_a) >>> ex_b[4:0]);
         AluOr:   ex_res = ex_a | ex_b;
         AluAnd:  ex_res = ex_a & ex_b;
         default: ex_res = '0;
      endcase
   end

   // EX/MEM and MEM/WB registers; MEM is a plain pass-through
   always_ff @(posedge clk) begin
      if (rstn) begin
         exmem_res_q <= '0;
         exmem_rd_q  <= '0;
         exmem_we_q  <= 1'b0;
         memwb_res_q <= '0;
         memwb_rd_q  <= '0;
         memwb_we_q  <= 1'b0;
      end else begin
         exmem_res_q <= ex_res;
         exmem_rd_q  <= idex_rd_q;
         exmem_we_q  <= idex_we_q;
         memwb_res_q <= exmem_res_q;
         memwb_rd_q  <= exmem_rd_q;
         memwb_we_q  <= exmem_we_q;
      end
   end

`ifdef RISCV_CORE_TRACE_EN
   // Simulation-only trace of every architectural register write
   always_ff @(posedge clk) begin
      if (!rstn && memwb_we_q && (memwb_rd_q != '0)) begin
         $display("WB x%0d = %h @ %0t", memwb_rd_q, memwb_res_q, $time);
      end
   end
`endif

endmodule

// File: tb/tb_riscv_pipe_core.sv
// Self-checking bench for riscv_pipe_core: table of small programs with
// hand-derived register results, reset/latency and wrap/mid-run-reset
// sequences, and random programs checked against a sequential ISA model.
module tb_riscv_pipe_core;

   localparam int unsigned DEPTH = 4096;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic clk  = 1'b0;
   logic rstn = 1'b1;

   always #5 clk = ~clk;

   riscv_pipe_core #(
      .ROM_DEPTH (DEPTH),
      .RESET_PC  (32'h0000_0000)
   ) dut (
      .clk  (clk),
      .rstn (rstn)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] prog_q [$];
   logic [31:0] mregs [32];

   typedef struct {
      string       name;
      logic [31:0] prog [8];
      int          rd   [5];
      logic [31:0] val  [5];
   } vec_t;

   vec_t vecs [5];

   function automatic logic [31:0] enc_i(input logic [2:0] f3, input int rd, input int rs1,
                                         input int imm);
      return {imm[11:0], rs1[4:0], f3, rd[4:0], 7'b0010011};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                         input int rd, input int rs1, input int rs2);
      return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'b0110011};
   endfunction

   function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
      return enc_i(3'd0, rd, rs1, imm);
   endfunction

   function automatic logic [31:0] rand_inst();
      int          kind, rd, rs1, rs2, imm;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] w;
      kind = $urandom_range(0, 19);
      f3   = 3'($urandom_range(0, 7));
      rd   = $urandom_range(0, 7);
      rs1  = $urandom_range(0, 7);
      rs2  = $urandom_range(0, 7);
      imm  = $urandom_range(0, 4095);
      if (kind < 9) begin
         if (f3 == 3'd1) imm = imm % 32;
         else if (f3 == 3'd5) imm = (imm % 32) + ($urandom_range(0, 1) * 1024);
         w = enc_i(f3, rd, rs1, imm);
      end else if (kind < 18) begin
         f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
         w  = enc_r(f7, f3, rd, rs1, rs2);
      end else if (kind == 18) begin
         w = 32'hFFFF_FFFF;
      end else begin
         w      = $urandom();
         w[6:0] = 7'b0110111;
      end
      return w;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_prog();
      for (int i = 0; i < DEPTH; i++) begin
         dut.u_rom.u_gnrl_rom.mem_r[i] = (i < prog_q.size()) ? prog_q[i] : NOP;
      end
   endtask

   // Hold reset for n edges, release on a falling edge
   task automatic do_reset(input int n);
      @(negedge clk);
      rstn = 1'b1;
      step(n);
      @(negedge clk);
      rstn = 1'b0;
   endtask

   // Architectural model: execute prog_q one instruction at a time
   task automatic model_run();
      logic [31:0] w, a, b, res;
      logic [6:0]  opc;
      logic [4:0]  sh;
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      foreach (prog_q[k]) begin
         w   = prog_q[k];
         opc = w[6:0];
         if (opc == 7'b0010011 || opc == 7'b0110011) begin
            a  = mregs[w[19:15]];
            b  = (opc == 7'b0010011) ? {{20{w[31]}}, w[31:20]} : mregs[w[24:20]];
            sh = b[4:0];
            case (w[14:12])
               3'd0:    res = (opc == 7'b0110011 && w[30]) ? a - b : a + b;
               3'd1:    res = a << sh;
               3'd2:    res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               3'd3:    res = (a < b) ? 32'd1 : 32'd0;
               3'd4:    res = a ^ b;
               3'd5:    res = w[30] ? 32'($signed(a) >>> sh) : a >> sh;
               3'd6:    res = a | b;
               default: res = a & b;
            endcase
            if (w[11:7] != 5'd0) mregs[w[11:7]] = res;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

   initial begin
      int nz;

      vecs[0].name = "chain";
      vecs[0].prog = '{addi(1, 0, 1), addi(2, 1, 2), addi(3, 2, 3), addi(4, 3, 4),
                       addi(5, 4, 5), NOP, NOP, NOP};
      vecs[0].rd   = '{1, 2, 3, 4, 5};
      vecs[0].val  = '{32'd1, 32'd3, 32'd6, 32'd10, 32'd15};

      vecs[1].name = "rtype";
      vecs[1].prog = '{addi(1, 0, -7), addi(2, 0, 3), enc_r(7'h20, 3'd0, 3, 1, 2),
                       enc_r(7'h00, 3'd2, 4, 1, 2), enc_r(7'h00, 3'd3, 5, 1, 2),
                       enc_i(3'd4, 6, 1, -1), NOP, NOP};
      vecs[1].rd   = '{3, 4, 5, 6, 1};
      vecs[1].val  = '{32'hFFFF_FFF6, 32'd1, 32'd0, 32'd6, 32'hFFFF_FFF9};

      vecs[2].name = "x0prot";
      vecs[2].prog = '{addi(7, 0, 9), addi(9, 0, 9), addi(0, 0, 5),
                       enc_r(7'h00, 3'd0, 7, 0, 0), enc_r(7'h00, 3'd0, 9, 0, 0), NOP, NOP, NOP};
      vecs[2].rd   = '{0, 7, 9, 0, 0};
      vecs[2].val  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

      vecs[3].name = "illegal";
      vecs[3].prog = '{addi(10, 0, 100), 32'hFFFF_FFFF, addi(11, 10, 5), NOP, NOP, NOP, NOP, NOP};
      vecs[3].rd   = '{10, 11, 31, 0, 0};
      vecs[3].val  = '{32'd100, 32'd105, 32'd0, 32'd0, 32'd0};

      vecs[4].name = "shift";
      vecs[4].prog = '{addi(1, 0, -16), addi(5, 0, 33), enc_i(3'd5, 2, 1, 12'h402),
                       enc_i(3'd5, 3, 1, 28), enc_i(3'd1, 4, 1, 4),
                       enc_r(7'h20, 3'd5, 6, 1, 5), enc_r(7'h00, 3'd5, 7, 1, 5), NOP};
      vecs[4].rd   = '{2, 3, 4, 6, 7};
      vecs[4].val  = '{32'hFFFF_FFFC, 32'h0000_000F, 32'hFFFF_FF00, 32'hFFFF_FFF8,
                       32'h7FFF_FFF8};

      // Table-driven programs
      for (int v = 0; v < 5; v++) begin
         prog_q = {};
         for (int j = 0; j < 8; j++) prog_q.push_back(vecs[v].prog[j]);
         load_prog();
         do_reset(2);
         step(20);
         for (int k = 0; k < 5; k++) begin
            check($sformatf("%s_x%0d", vecs[v].name, vecs[v].rd[k]),
                  dut.u_regfile.regs_mem[vecs[v].rd[k]], vecs[v].val[k]);
         end
      end

      // Logic ops and immediate compares, expectations from the model
      prog_q = {addi(1, 0, 240), addi(2, 0, 255), enc_r(7'h00, 3'd6, 3, 1, 2),
                enc_r(7'h00, 3'd7, 4, 1, 2), enc_r(7'h00, 3'd4, 5, 1, 2),
                enc_i(3'd3, 6, 0, -1), enc_i(3'd2, 7, 1, -1), enc_i(3'd6, 8, 1, 12'h800)};
      load_prog();
      model_run();
      do_reset(2);
      step(20);
      for (int r = 1; r < 9; r++) begin
         check($sformatf("logic_x%0d", r), dut.u_regfile.regs_mem[r], mregs[r]);
      end

      // Reset state and first-writeback latency (regs are non-zero beforehand)
      prog_q = {addi(1, 0, 1)};
      load_prog();
      @(negedge clk);
      rstn = 1'b1;
      step(2);
      check("reset_pc", dut.pc_q, 32'h0);
      nz = 0;
      for (int r = 0; r < 32; r++) if (dut.u_regfile.regs_mem[r] != 32'd0) nz++;
      check("reset_regs_nonzero", 32'(nz), 32'd0);
      @(negedge clk);
      rstn = 1'b0;
      step(4);
      check("pre_wb_x1", dut.u_regfile.regs_mem[1], 32'd0);
      check("pc_after_4", dut.pc_q, 32'd16);
      step(1);
      check("first_wb_x1", dut.u_regfile.regs_mem[1], 32'd1);

      // Random dependent programs over x0..x7 against the model
      for (int round = 0; round < 3; round++) begin
         prog_q = {};
         for (int r = 1; r < 8; r++) prog_q.push_back(addi(r, 0, $urandom_range(0, 4095)));
         for (int i = 0; i < 40; i++) prog_q.push_back(rand_inst());
         load_prog();
         model_run();
         do_reset(2);
         step(prog_q.size() + 10);
         for (int r = 0; r < 8; r++) begin
            check($sformatf("rand%0d_x%0d", round, r), dut.u_regfile.regs_mem[r], mregs[r]);
         end
      end

      // PC wrap over the whole ROM, then a one-cycle reset mid-run
      prog_q = {};
      for (int i = 0; i < DEPTH; i++) prog_q.push_back(addi(1, 1, 1));
      load_prog();
      do_reset(2);
      step(4200);
      check("wrap_x1", dut.u_regfile.regs_mem[1], 32'd4196);
      check("wrap_pc", dut.pc_q, 32'd16800);
      @(negedge clk);
      rstn = 1'b1;
      step(1);
      check("midrst_x1", dut.u_regfile.regs_mem[1], 32'd0);
      check("midrst_pc", dut.pc_q, 32'd0);
      @(negedge clk);
      rstn = 1'b0;
      step(10);
      check("restart_x1", dut.u_regfile.regs_mem[1], 32'd6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
